// File: rtl/io_pkg.sv
// Shared constants and types for the io_uart peripheral: register map, STATUS bit layout,
// FSM state encoding and the baud divisor floor.
package io_pkg;

    localparam logic [3:0] REG_TXDATA  = 4'h0;
    localparam logic [3:0] REG_RXDATA  = 4'h4;
    localparam logic [3:0] REG_STATUS  = 4'h8;
    localparam logic [3:0] REG_BAUDDIV = 4'hC;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_TX_BUSY   = 2;
    localparam int ST_RX_VALID  = 3;
    localparam int ST_RX_OVR    = 4;
    localparam int ST_TX_OVF    = 5;
    localparam int ST_FRAME_ERR = 6;

    localparam logic [15:0] BAUD_MIN = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    // Below 4 the RX half-bit wait would collapse to a single cycle or less.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < BAUD_MIN) ? BAUD_MIN : v;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
// Data at the head is presented combinationally; pushes while full are ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok  = push_i & ~full_o;
    assign pop_ok   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: TX FIFO, single-entry RX holding register, sticky flags, baud divisor.
// Reads are combinational from io_addr; writes and read side effects land on the io_ce edge.
module io_uart
    import io_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ce,
    input  logic        io_we,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_din,
    output logic [31:0] io_dout,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

    logic        mapped;
    logic [3:0]  reg_off;
    logic        wr_tx, wr_status, wr_baud, rd_rx;
    logic        unused_bits;

    assign mapped    = (io_addr[15:4] == 12'h000);
    assign reg_off   = {io_addr[3:2], 2'b00};
    assign wr_tx     = io_ce &  io_we & mapped & (reg_off == REG_TXDATA);
    assign wr_status = io_ce &  io_we & mapped & (reg_off == REG_STATUS);
    assign wr_baud   = io_ce &  io_we & mapped & (reg_off == REG_BAUDDIV);
    assign rd_rx     = io_ce & ~io_we & mapped & (reg_off == REG_RXDATA);
    assign unused_bits = ^{io_addr[31:16], io_addr[1:0], io_din[31:16]};

    logic [15:0] baud_q, baud_d;

    uart_state_e tx_st_q, tx_st_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        txd_q, txd_d;
    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  fifo_dout;

    logic [1:0]  rx_sync_q;
    logic        rxs;
    uart_state_e rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_load, rx_ferr;

    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] status;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (wr_tx),
        .din_i   (io_din[7:0]),
        .pop_i   (tx_pop),
        .dout_o  (fifo_dout),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign uart_txd = txd_q;
    assign rxs      = rx_sync_q[1];

    // The divisor is sampled only when a bit period is (re)loaded, so changes land on bit boundaries.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txd_d    = txd_q;
        tx_pop   = 1'b0;
        case (tx_st_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop   = 1'b1;
                    tx_sh_d  = fifo_dout;
                    tx_cnt_d = baud_q - 16'd1;
                    txd_d    = 1'b0;
                    tx_st_d  = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_st_d  = S_DATA;
                    tx_cnt_d = baud_q - 16'd1;
                    tx_bit_d = 3'd0;
                    txd_d    = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = baud_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                        txd_d    = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_st_d = S_IDLE;
                    txd_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_st_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_load  = 1'b0;
        rx_ferr  = 1'b0;
        case (rx_st_q)
            S_IDLE: begin
                if (!rxs) begin
                    rx_st_d  = S_START;
                    rx_cnt_d = (baud_q >> 1) - 16'd1;
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (!rxs) begin
                        rx_st_d  = S_DATA;
                        rx_cnt_d = baud_q - 16'd1;
                        rx_bit_d = 3'd0;
                    end else begin
                        rx_st_d = S_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_sh_d  = {rxs, rx_sh_q[7:1]};
                    rx_cnt_d = baud_q - 16'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_st_d = S_IDLE;
                    rx_load = rxs;
                    rx_ferr = ~rxs;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    // Set conditions are OR-ed in after the clear terms so a coincident set always wins.
    always_comb begin
        baud_d      = wr_baud ? clamp_div(io_din[15:0]) : baud_q;
        rx_byte_d   = rx_load ? rx_sh_q : rx_byte_q;
        rx_valid_d  = rx_load | (rx_valid_q & ~rd_rx);
        rx_ovr_d    = (rx_load & rx_valid_q & ~rd_rx)
                    | (rx_ovr_q & ~(wr_status & io_din[ST_RX_OVR]));
        tx_ovf_d    = (wr_tx & tx_full)
                    | (tx_ovf_q & ~(wr_status & io_din[ST_TX_OVF]));
        frame_err_d = rx_ferr
                    | (frame_err_q & ~(wr_status & io_din[ST_FRAME_ERR]));
    end

    always_comb begin
        status               = 32'h0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_BUSY]   = (tx_st_q != S_IDLE);
        status[ST_RX_VALID]  = rx_valid_q;
        status[ST_RX_OVR]    = rx_ovr_q;
        status[ST_TX_OVF]    = tx_ovf_q;
        status[ST_FRAME_ERR] = frame_err_q;
    end

    always_comb begin
        io_dout = 32'h0;
        if (mapped) begin
            case (reg_off)
                REG_RXDATA:  io_dout = {24'h0, rx_byte_q};
                REG_STATUS:  io_dout = status;
                REG_BAUDDIV: io_dout = {16'h0, baud_q};
                default:     io_dout = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q      <= DIV_RST;
            tx_st_q     <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            txd_q       <= 1'b1;
            rx_sync_q   <= 2'b11;
            rx_st_q     <= S_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            baud_q      <= baud_d;
            tx_st_q     <= tx_st_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            txd_q       <= txd_d;
            rx_sync_q   <= {rx_sync_q[0], uart_rxd};
            rx_st_q     <= rx_st_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_ovf_q    <= tx_ovf_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: register map, TX waveform, FIFO overflow, RX framing and reset abort.
`timescale 1ns/1ps
module tb_io_uart;

    localparam int          CLK_DIV = 434;
    localparam logic [31:0] A_TX    = 32'hBFD0_0000;
    localparam logic [31:0] A_RX    = 32'hBFD0_0004;
    localparam logic [31:0] A_ST    = 32'hBFD0_0008;
    localparam logic [31:0] A_BD    = 32'hBFD0_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_ce, io_we;
    logic [31:0] io_addr, io_din, io_dout;
    logic        uart_rxd, uart_txd;

    int n_vec = 0;
    int n_err = 0;

    io_uart #(
        .FIFO_DEPTH (16),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_ce    (io_ce),
        .io_we    (io_we),
        .io_addr  (io_addr),
        .io_din   (io_din),
        .io_dout  (io_dout),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        io_ce = 1'b1; io_we = 1'b1; io_addr = a; io_din = d;
        tick(1);
        io_ce = 1'b0; io_we = 1'b0;
    endtask

    task automatic io_read(input logic [31:0] a, output logic [31:0] d);
        io_ce = 1'b1; io_we = 1'b0; io_addr = a;
        #1;
        d = io_dout;
        tick(1);
        io_ce = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // 16 clocks per bit, matching the divisor programmed before every RX test.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(16);
        end
        uart_rxd = stop_bit;
        tick(16);
        uart_rxd = 1'b1;
        tick(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  pat;
        logic        exp_bit;
        int          zc;

        io_ce = 1'b0; io_we = 1'b0; io_addr = '0; io_din = '0;
        uart_rxd = 1'b1;
        rst = 1'b1;
        tick(3);
        chk("txd_in_reset", uart_txd, 1);
        rst = 1'b0;
        tick(1);

        io_read(A_ST, d);           chk("reset_status", d, 32'h02);
        io_read(A_BD, d);           chk("reset_bauddiv", d, CLK_DIV);
        chk("reset_txd", uart_txd, 1);
        io_write(A_BD, 32'd2);
        io_read(A_BD, d);           chk("baud_clamp", d, 32'd4);
        io_write(A_BD, 32'd16);
        io_read(A_BD, d);           chk("baud_16", d, 32'd16);
        io_write(32'hBFD0_001C, 32'd40);
        io_read(A_BD, d);           chk("unmapped_write", d, 32'd16);
        io_read(32'hBFD0_0018, d);  chk("unmapped_read", d, 32'h0);
        io_read(A_ST + 32'd2, d);   chk("low_addr_ignored", d, 32'h02);
        io_read(A_TX, d);           chk("txdata_reads_0", d, 32'h0);

        // TX waveform for 0x55; k counts edges after the write edge.
        pat = 8'h55;
        io_write(A_TX, 32'h55);
        chk("tx_before_start", uart_txd, 1);
        io_addr = A_ST;
        for (int k = 1; k <= 160; k++) begin
            tick(1);
            if (k <= 16)       exp_bit = 1'b0;
            else if (k <= 144) exp_bit = pat[(k - 17) / 16];
            else               exp_bit = 1'b1;
            chk($sformatf("tx_wave_k%0d", k), uart_txd, exp_bit);
            if (k == 1)      chk("tx_status_start", io_dout, 32'h06);
            if (k % 16 == 8) chk($sformatf("tx_busy_k%0d", k), io_dout[2], 1);
        end
        tick(1);
        chk("tx_done_status", io_dout, 32'h02);

        // Overflow: 1 popped, 16 queued, 18th dropped while the first byte is on the wire.
        for (int i = 0; i < 18; i++) io_write(A_TX, 32'h30 + i);
        io_read(A_ST, d);           chk("ovf_status", d, 32'h25);
        io_write(A_ST, 32'h27);
        io_read(A_ST, d);           chk("ovf_w1c", d, 32'h05);

        do_reset();
        io_write(A_BD, 32'd16);

        rx_frame(8'hA3, 1'b1);
        io_addr = A_ST;
        #1;
        chk("rx_valid_set", io_dout, 32'h0A);
        io_read(A_RX, d);           chk("rx_data_a3", d, 32'hA3);
        io_read(A_ST, d);           chk("rx_valid_cleared", d, 32'h02);

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        io_read(A_ST, d);           chk("rx_ovr_status", d, 32'h1A);
        io_read(A_RX, d);           chk("rx_ovr_data", d, 32'h22);
        io_write(A_ST, 32'h10);
        io_read(A_ST, d);           chk("rx_ovr_w1c", d, 32'h02);

        rx_frame(8'h5A, 1'b0);
        io_read(A_ST, d);           chk("frame_err_status", d, 32'h42);
        io_read(A_RX, d);           chk("frame_err_data", d, 32'h22);
        io_write(A_ST, 32'h40);
        io_read(A_ST, d);           chk("frame_err_w1c", d, 32'h02);

        uart_rxd = 1'b0;
        tick(3);
        uart_rxd = 1'b1;
        tick(30);
        io_read(A_ST, d);           chk("glitch_status", d, 32'h02);
        io_read(A_RX, d);           chk("glitch_data", d, 32'h22);

        // Reset in the middle of data bit 4 of 0x0F (a 0 bit) with four more bytes queued.
        do_reset();
        io_write(A_BD, 32'd16);
        io_write(A_TX, 32'h0F);
        for (int i = 1; i < 5; i++) io_write(A_TX, i);
        tick(84);
        chk("pre_reset_bit4", uart_txd, 0);
        rst = 1'b1;
        #1;
        chk("reset_txd_immediate", uart_txd, 1);
        tick(2);
        rst = 1'b0;
        tick(1);
        io_read(A_ST, d);           chk("post_reset_status", d, 32'h02);
        io_read(A_BD, d);           chk("post_reset_bauddiv", d, CLK_DIV);
        zc = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (!uart_txd) zc++;
        end
        chk("no_tx_after_reset", zc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
